// File: rtl/reorder_buffer_if.sv
// Reorder buffer bus: allocate, writeback, operand query, commit, rollback.
// master = decode/execute/memory side, slave = reorder_buffer.
interface reorder_buffer_if #(
  parameter int DEPTH_LOG = 4,
  parameter int XLEN      = 32
);
  logic                 alloc_valid;
  logic [1:0]           alloc_type;
  logic [4:0]           alloc_rd;
  logic [31:0]          alloc_pc;
  logic                 alloc_pred;
  logic [DEPTH_LOG-1:0] alloc_id;
  logic                 full;

  logic                 wb_valid;
  logic [DEPTH_LOG-1:0] wb_id;
  logic [XLEN-1:0]      wb_value;
  logic                 wb_taken;
  logic [31:0]          wb_target;

  logic [DEPTH_LOG-1:0] q1_id;
  logic [DEPTH_LOG-1:0] q2_id;
  logic [XLEN-1:0]      q1_value;
  logic [XLEN-1:0]      q2_value;
  logic                 q1_ready;
  logic                 q2_ready;

  logic                 commit_valid;
  logic [1:0]           commit_type;
  logic [4:0]           commit_rd;
  logic [XLEN-1:0]      commit_value;
  logic [DEPTH_LOG-1:0] commit_id;
  logic                 store_ack;

  logic                 rollback;
  logic [31:0]          rollback_pc;
  logic                 halt;
  logic [DEPTH_LOG:0]   count;

  modport master (
    output alloc_valid, alloc_type, alloc_rd, alloc_pc, alloc_pred,
    input  alloc_id, full,
    output wb_valid, wb_id, wb_value, wb_taken, wb_target,
    output q1_id, q2_id,
    input  q1_value, q2_value, q1_ready, q2_ready,
    input  commit_valid, commit_type, commit_rd, commit_value, commit_id,
    output store_ack,
    input  rollback, rollback_pc, halt, count
  );

  modport slave (
    input  alloc_valid, alloc_type, alloc_rd, alloc_pc, alloc_pred,
    output alloc_id, full,
    input  wb_valid, wb_id, wb_value, wb_taken, wb_target,
    input  q1_id, q2_id,
    output q1_value, q2_value, q1_ready, q2_ready,
    output commit_valid, commit_type, commit_rd, commit_value, commit_id,
    input  store_ack,
    output rollback, rollback_pc, halt, count
  );
endinterface

// File: rtl/reorder_buffer.sv
// Circular reorder buffer with in-order commit, store handshake, branch
// rollback and sticky halt. Ports: clk, rst (sync, active-high), rdy
// (global enable), bus (reorder_buffer_if.slave). Optional macro
// ROB_BYPASS_EN forwards a same-cycle writeback to the operand queries.
module reorder_buffer #(
  parameter int DEPTH_LOG = 4,
  parameter int XLEN      = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rdy,
  reorder_buffer_if.slave bus
);
  localparam int N = 1 << DEPTH_LOG;
  localparam logic [DEPTH_LOG:0] NCNT = N[DEPTH_LOG:0];

  localparam logic [1:0] T_REG  = 2'b00;
  localparam logic [1:0] T_ST   = 2'b01;
  localparam logic [1:0] T_BR   = 2'b10;
  localparam logic [1:0] T_HALT = 2'b11;

  logic [DEPTH_LOG-1:0] head;
  logic [DEPTH_LOG-1:0] tail;
  logic [DEPTH_LOG:0]   cnt;

  logic [N-1:0]    busy;
  logic [N-1:0]    ready;
  logic [N-1:0]    pred;
  logic [N-1:0]    taken;
  logic [1:0]      etype  [N];
  logic [4:0]      rd     [N];
  logic [31:0]     pc     [N];
  logic [31:0]     target [N];
  logic [XLEN-1:0] value  [N];

  // Set while a store sits at head waiting for store_ack.
  logic st_pend;

  logic                 c_valid;
  logic [1:0]           c_type;
  logic [4:0]           c_rd;
  logic [XLEN-1:0]      c_value;
  logic [DEPTH_LOG-1:0] c_id;
  logic                 rb;
  logic [31:0]          rb_pc;
  logic                 halted;

  logic       full;
  logic       accept;
  logic       fire;
  logic       ack_done;
  logic       retire;
  logic [1:0] ht;
  logic       mispred;

  assign full     = cnt == NCNT;
  assign accept   = bus.alloc_valid && !full && !rb;
  assign ht       = etype[head];
  assign fire     = busy[head] && ready[head]
                 && !halted && !rb && !st_pend;
  assign mispred  = ht == T_BR && taken[head] != pred[head];
  assign ack_done = st_pend && bus.store_ack;
  assign retire   = (fire && ht != T_ST) || ack_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      cnt     <= '0;
      busy    <= '0;
      st_pend <= 1'b0;
      c_valid <= 1'b0;
      c_type  <= '0;
      c_rd    <= '0;
      c_value <= '0;
      c_id    <= '0;
      rb      <= 1'b0;
      rb_pc   <= '0;
      halted  <= 1'b0;
    end else if (rdy) begin
      if (rb) begin
        // Flush edge: everything younger than the branch is discarded.
        head    <= '0;
        tail    <= '0;
        cnt     <= '0;
        busy    <= '0;
        st_pend <= 1'b0;
        c_valid <= 1'b0;
        rb      <= 1'b0;
      end else begin
        if (accept) begin
          busy[tail]   <= 1'b1;
          ready[tail]  <= 1'b0;
          etype[tail]  <= bus.alloc_type;
          rd[tail]     <= bus.alloc_rd;
          pc[tail]     <= bus.alloc_pc;
          pred[tail]   <= bus.alloc_pred;
          tail         <= tail + DEPTH_LOG'(1);
        end
        if (bus.wb_valid && busy[bus.wb_id]) begin
          ready[bus.wb_id]  <= 1'b1;
          value[bus.wb_id]  <= bus.wb_value;
          taken[bus.wb_id]  <= bus.wb_taken;
          target[bus.wb_id] <= bus.wb_target;
        end
        // A pending store keeps its record visible until acknowledged.
        c_valid <= st_pend && !bus.store_ack;
        if (fire) begin
          c_valid <= 1'b1;
          c_type  <= ht;
          c_rd    <= rd[head];
          c_value <= value[head];
          c_id    <= head;
          if (ht == T_ST) begin
            st_pend <= 1'b1;
          end else begin
            busy[head] <= 1'b0;
            head       <= head + DEPTH_LOG'(1);
          end
          if (ht == T_HALT) halted <= 1'b1;
          if (mispred) begin
            rb    <= 1'b1;
            rb_pc <= taken[head] ? target[head]
                                 : pc[head] + 32'd4;
          end
        end
        if (ack_done) begin
          st_pend    <= 1'b0;
          busy[head] <= 1'b0;
          head       <= head + DEPTH_LOG'(1);
        end
        cnt <= cnt + (DEPTH_LOG+1)'(accept)
                   - (DEPTH_LOG+1)'(retire);
      end
    end
  end

`ifdef ROB_BYPASS_EN
  logic hit1;
  logic hit2;
  assign hit1 = bus.wb_valid && bus.wb_id == bus.q1_id;
  assign hit2 = bus.wb_valid && bus.wb_id == bus.q2_id;
  assign bus.q1_value = hit1 ? bus.wb_value : value[bus.q1_id];
  assign bus.q2_value = hit2 ? bus.wb_value : value[bus.q2_id];
  assign bus.q1_ready = hit1 || (busy[bus.q1_id] && ready[bus.q1_id]);
  assign bus.q2_ready = hit2 || (busy[bus.q2_id] && ready[bus.q2_id]);
`else
  assign bus.q1_value = value[bus.q1_id];
  assign bus.q2_value = value[bus.q2_id];
  assign bus.q1_ready = busy[bus.q1_id] && ready[bus.q1_id];
  assign bus.q2_ready = busy[bus.q2_id] && ready[bus.q2_id];
`endif

  assign bus.alloc_id     = tail;
  assign bus.full         = full;
  assign bus.count        = cnt;
  assign bus.commit_valid = c_valid;
  assign bus.commit_type  = c_type;
  assign bus.commit_rd    = c_rd;
  assign bus.commit_value = c_value;
  assign bus.commit_id    = c_id;
  assign bus.rollback     = rb;
  assign bus.rollback_pc  = rb_pc;
  assign bus.halt         = halted;
endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH_LOG, default 4, entry count = 2**DEPTH_LOG.
REQ-002 The block SHALL have parameter XLEN, default 32, result value width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 rdy  in  1  global enable; low freezes all state and registered outputs.
REQ-006 alloc_valid  in  1  decoder requests a new entry this cycle.
REQ-007 alloc_type  in  2  entry type: 00 reg write, 01 store, 10 branch, 11 halt.
REQ-008 alloc_rd / alloc_pc / alloc_pred  in  5 / 32 / 1  destination register, instruction PC, predicted-taken.
REQ-009 alloc_id  out  DEPTH_LOG  tag of the entry the next accepted allocation receives (= tail).
REQ-010 full  out  1  count == 2**DEPTH_LOG.
REQ-011 wb_valid / wb_id / wb_value / wb_taken / wb_target  in  1 / DEPTH_LOG / XLEN / 1 / 32  result broadcast.
REQ-012 q1_id, q2_id  in  DEPTH_LOG; q1_value, q2_value  out  XLEN; q1_ready, q2_ready  out  1  operand lookups.
REQ-013 commit_valid / commit_type / commit_rd / commit_value / commit_id  out  1 / 2 / 5 / XLEN / DEPTH_LOG  registered commit record.
REQ-014 store_ack  in  1  memory side has accepted the committing store.
REQ-015 rollback / rollback_pc  out  1 / 32  misprediction flush pulse and redirect PC.
REQ-016 halt  out  1  sticky; halt entry committed.
REQ-017 count  out  DEPTH_LOG+1  occupied entries.

Function
REQ-018 The buffer SHALL be circular, with head and tail modulo 2**DEPTH_LOG; wrap-around SHALL need no extra cycle.
REQ-019 Allocation SHALL be accepted when alloc_valid && !full && !rollback: entry[tail] busy=1, ready=0, fields stored, tail+1.
REQ-020 Allocation while full SHALL be dropped with no state change; full SHALL be evaluated from start-of-cycle count, so a same-cycle commit does not admit it.
REQ-021 Writeback SHALL set ready, value, taken and target of entry wb_id when busy; writeback to a non-busy entry SHALL be ignored.
REQ-022 Queries SHALL be combinational: qN_value = value[qN_id], qN_ready = busy & ready of that entry.
REQ-023 Commit SHALL occur when the head entry is busy and ready; registered commit_* become valid the following cycle, so writeback at cycle N commits at N+1 at the earliest.
REQ-024 Types 00/10/11 SHALL commit in one cycle: commit_valid pulses one cycle, head+1, busy cleared.
REQ-025 Type 01 SHALL hold commit_valid and head until the cycle store_ack=1; head advances on that edge.
REQ-026 A committing branch with wb_taken != pred SHALL pulse rollback one cycle with rollback_pc = taken ? wb_target : pc+4, also asserting commit_valid for predictor update.
REQ-027 On the rollback edge all busy bits, head, tail and count SHALL clear; allocation and writeback in that cycle SHALL be ignored.
REQ-028 A committing halt entry SHALL set halt, which stays 1 until reset, and SHALL block further commits.
REQ-029 count SHALL update as count + accept - commit, so simultaneous accept and commit leave it unchanged.
REQ-030 With rdy=0 no state or output register SHALL change; consumers gate commit_valid and rollback with rdy.

Reset
REQ-031 rst=1 SHALL take priority over rdy and clear head, tail, count, all busy bits, commit_valid, commit_type, commit_rd, commit_value, commit_id, rollback, rollback_pc and halt to 0.
REQ-032 After reset, full=0, alloc_id=0 and qN_ready=0 for all ids.

Configuration
REQ-033 With ROB_BYPASS_EN defined, a query whose qN_id equals wb_id while wb_valid=1 SHALL return wb_value with qN_ready=1 in the same cycle.
REQ-034 Without ROB_BYPASS_EN, that query SHALL return stored entry contents, with ready visible from the next cycle.

Verification
REQ-035 Reset, then allocate 16 reg-write entries (DEPTH_LOG=4) -> full=1, count=16; a 17th alloc_valid is dropped.
REQ-036 Writeback id 3 value 0xDEADBEEF, then query q1_id=3 -> q1_ready=1, q1_value=0xDEADBEEF; same-cycle query follows REQ-033/034 per macro.
REQ-037 Head store ready with store_ack low 3 cycles -> commit_valid held 3 cycles, head advances on the ack cycle only.
REQ-038 Branch pc=0x100, pred=0, wb_taken=1, target=0x200 at head -> rollback pulse, rollback_pc=0x200, count=0 next cycle.
REQ-039 Fill, commit 2, allocate 2 -> tail wraps to 2; ids 0 and 1 reused and commit in order.
REQ-040 rdy=0 for 4 cycles mid-stream -> no output change; rst asserted mid-store -> all outputs 0 next cycle.
